// File: rtl/prio_encoder_q.sv
// Registered N-to-log2(N) priority encoder with request queueing and valid/ready output.
// Define PRIO_ENCODER_Q_RR_EN for round-robin priority; fixed priority (highest index wins) otherwise.
module prio_encoder_q #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         dup,
  output logic         busy
);

  logic [N-1:0] pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         dup_q, dup_d;
  logic         busy_q, busy_d;

  logic [N-1:0] cand;
  logic [N-1:0] grant_mask;
  logic [W-1:0] sel;
  logic         load;

`ifdef PRIO_ENCODER_Q_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] pos;
  logic         found;
`endif

  // Selection over pending | req so a fresh request can be granted on the edge it is sampled
  always_comb begin
    cand = pending_q | req;
    sel  = '0;
`ifdef PRIO_ENCODER_Q_RR_EN
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = W'((int'(ptr_q) + int'(N) - k) % int'(N));
      if (!found && cand[pos]) begin
        found = 1'b1;
        sel   = pos;
      end
    end
`else
    for (int i = 0; i < int'(N); i++) begin
      if (cand[i]) sel = W'(i);
    end
`endif
    load       = (!out_valid_q || out_ready) && (|cand);
    grant_mask = load ? (N'(1) << sel) : '0;
  end

  // Next-state for the queue, output slot and status flags
  always_comb begin
    pending_d   = cand & ~grant_mask;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    dup_d  = |(req & pending_q);
    busy_d = out_valid_d | (|pending_d);
`ifdef PRIO_ENCODER_Q_RR_EN
    ptr_d = ptr_q;
    if (load) ptr_d = (sel == '0) ? W'(N - 1) : sel - W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      dup_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      dup_q       <= dup_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PRIO_ENCODER_Q_RR_EN
  // Rotation pointer marks the current highest-priority index
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign dup       = dup_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed-vector bench for prio_encoder_q (N=8); round-robin expectations under PRIO_ENCODER_Q_RR_EN.
module tb_prio_encoder_q;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         dup;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] obs;
  logic [13:0] exp_v;

  prio_encoder_q #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .dup       (dup),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, out_idx, pending, dup, busy};

  // Packs expected {out_valid, out_idx, pending, dup, busy}
  function automatic logic [13:0] pk(input logic v, input logic [2:0] idx,
                                     input logic [7:0] pend, input logic d, input logic b);
    return {v, idx, pend, d, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_hold%0d got %h exp %h", e, obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
      end
    end
    rst_n = 1'b1; req = '0;
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_release got %h exp %h", obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08; out_ready = 1'b1;
    tick();
    req = '0;
    n_checks++;
    if (obs !== pk(1'b1, 3'd3, 8'h00, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL single_grant got %h exp %h", obs, pk(1'b1, 3'd3, 8'h00, 1'b0, 1'b1));
    end
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd3, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL single_idle got %h exp %h", obs, pk(1'b0, 3'd3, 8'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_burst();
    logic [2:0] idx_seq [4];
    logic [7:0] pend_seq [4];
    idx_seq  = '{3'd7, 3'd5, 3'd2, 3'd0};
    pend_seq = '{8'b0010_0101, 8'b0000_0101, 8'b0000_0001, 8'h00};
    do_reset();
    req = 8'b1010_0101; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      req = '0;
      exp_v = pk(1'b1, idx_seq[c], pend_seq[c], 1'b0, 1'b1);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL burst_%0d got %h exp %h", c, obs, exp_v);
      end
    end
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL burst_end got %h exp %h", obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_backpressure_dup();
    do_reset();
    out_ready = 1'b0; req = 8'h01;
    tick();
    n_checks++;
    if (obs !== pk(1'b1, 3'd0, 8'h00, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_first got %h exp %h", obs, pk(1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
    end
    tick();
    n_checks++;
    if (obs !== pk(1'b1, 3'd0, 8'h01, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_inflight got %h exp %h", obs, pk(1'b1, 3'd0, 8'h01, 1'b0, 1'b1));
    end
    tick();
    req = '0; out_ready = 1'b1;
    n_checks++;
    if (obs !== pk(1'b1, 3'd0, 8'h01, 1'b1, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_dup got %h exp %h", obs, pk(1'b1, 3'd0, 8'h01, 1'b1, 1'b1));
    end
    tick();
    n_checks++;
    if (obs !== pk(1'b1, 3'd0, 8'h00, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_drain got %h exp %h", obs, pk(1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
    end
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_idle got %h exp %h", obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] reqs [3];
    reqs = '{8'h01, 8'h02, 8'h04};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req = reqs[c];
      tick();
      exp_v = pk(1'b1, 3'(c), 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_%0d got %h exp %h", c, obs, exp_v);
      end
    end
    req = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end got %b exp 0", out_valid);
    end
  endtask

  task automatic test_priority_mode();
    do_reset();
    out_ready = 1'b1; req = 8'b1000_0001;
    for (int c = 0; c < 4; c++) begin
      tick();
`ifdef PRIO_ENCODER_Q_RR_EN
      exp_v = {1'b1, (c % 2 == 0) ? 3'd7 : 3'd0};
`else
      exp_v = {1'b1, 3'd7};
`endif
      n_checks++;
      if ({out_valid, out_idx} !== exp_v[3:0]) begin
        n_fail++;
        $display("FAIL prio_%0d got %h exp %h", c, {out_valid, out_idx}, exp_v[3:0]);
      end
`ifndef PRIO_ENCODER_Q_RR_EN
      n_checks++;
      if (pending[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL prio_pend0_%0d got %b exp 1", c, pending[0]);
      end
`endif
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; req = 8'h01;
    tick();
    req = 8'h30;
    tick();
    n_checks++;
    if (obs !== pk(1'b1, 3'd0, 8'h30, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL mid_setup got %h exp %h", obs, pk(1'b1, 3'd0, 8'h30, 1'b0, 1'b1));
    end
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL mid_reset got %h exp %h", obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    end
    rst_n = 1'b1; req = '0;
    tick();
    n_checks++;
    if (obs !== pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL mid_release got %h exp %h", obs, pk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure_dup();
    test_back_to_back();
    test_priority_mode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_q.md
# prio_encoder_q

Parametrised, registered N-to-log2(N) priority encoder with request queueing and a valid/ready output handshake. It generalises the 4x2 combinational encoder:
- Simultaneous or back-to-back request bits are captured in a pending register rather than lost.
- Pending requests are emitted one index per accepted transfer, highest priority first.
- Optional round-robin mode prevents starvation of low-priority lines.

It sits between raw event/request lines and a single-index consumer (interrupt controller, arbiter, channel dispatcher).

## Interface
- N, default 8: number of request lines; legal range 2..64.
- W (localparam), derived as $clog2(N): width of the index output.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  request lines, sampled every rising edge; a 1 on bit i sets pending bit i.
- out_valid  output  1  out_idx holds a granted request.
- out_ready  input  1  consumer accepts; transfer occurs on an edge where out_valid && out_ready.
- out_idx  output  W  index of the granted request.
- pending  output  N  requests captured but not yet granted.
- dup  output  1  one-cycle pulse: a req bit arrived while the same bit was already pending.
- busy  output  1  equals out_valid | (|pending).

## Operation
- **Capture:** `pending_next = (pending | req) & ~grant_mask`, where grant_mask is one-hot of the index loaded this edge, or 0 if no load.
- **Load condition:** `load = (!out_valid || out_ready) && |(pending | req)`.
- **Selection:**
  - The candidate set is `pending | req` (bypass), so a fresh request can be granted on the edge it is sampled.
  - The chosen index is written to out_idx, and out_valid is set.
- **Idle output:** if out_valid && out_ready and the candidate set is empty, out_valid clears and out_idx holds its last value.
- **Stall:** while out_valid && !out_ready, out_idx and out_valid hold, and requests keep accumulating in pending.
- **dup:** registered; set for one cycle after any edge where `|(req & pending)` is true. The request is merged; only one grant results.
- **In-flight index:** a req bit equal to the index currently held in out_idx, with out_valid=1, is a new request. It goes into pending and does not raise dup.
- **Fixed priority:** the highest set index wins (bit N-1 highest, bit 0 lowest).
- **Width:** out_idx is zero-extended to W bits. Indices ≥ N never occur.

## Timing
- Reset values (rst_n=0 at an edge): pending=0, out_valid=0, out_idx=0, dup=0, rotation pointer=N-1.
- Reset takes priority over all activity, including a transfer in progress. Requests sampled on the reset edge are discarded.
- Latency, req to out_valid: 1 edge when the output slot is free or being accepted on the same edge.
- Throughput: one grant per cycle with out_ready held high.
- pending, dup and busy are registered. No combinational path exists from req or out_ready to any output.
- Simultaneous grant and capture of the same bit i on one edge: i is granted, pending[i]=0 afterwards, and dup follows the dup rule only.

## Configuration
- Macro: PRIO_ENCODER_Q_RR_EN.
- **Defined:** round-robin priority.
  - A pointer p (reset N-1) marks the highest-priority index.
  - Search order is p, p-1, …, 0, N-1, …, p+1.
  - After each load of index g, p becomes (g-1) mod N, so g becomes the lowest priority.
  - Wrap from 0 goes to N-1.
- **Undefined:** fixed priority as above. The pointer logic is absent.

## Test plan
- **Reset:**
  - Drive req=8'hFF, out_ready=1 with rst_n=0 for 3 edges, then release with req=0 → pending=0, out_valid=0, out_idx=0, dup=0, busy=0 throughout.
- **Single request:**
  - N=8, out_ready=1, req=8'h08 for one cycle → next edge out_valid=1, out_idx=3, pending=0.
  - Following edge → out_valid=0.
- **Burst, fixed priority:**
  - req=8'b1010_0101 for one cycle, out_ready=1 → out_idx sequence 7,5,2,0 on consecutive cycles, then out_valid=0.
  - pending after the first edge is 8'b0010_0101.
- **Backpressure and dup:**
  - Hold out_ready=0, req=8'h01 for 2 consecutive cycles → out_valid=1 with out_idx=0, and pending=8'h01 after the second edge. dup stays 0: the first sample was granted directly and the second is a new request for the in-flight index.
  - A third cycle of req=8'h01 → dup=1 for one cycle.
  - Set out_ready=1 → idx 0 is accepted, the pending idx 0 follows, then out_valid=0.
- **Round-robin (PRIO_ENCODER_Q_RR_EN):**
  - Hold req=8'b1000_0001 every cycle, out_ready=1 → out_idx alternates 7,0,7,0.
  - Without the macro, out_idx stays 7 every cycle and bit 0 remains pending.
- **Reset mid-operation:**
  - With out_valid=1, out_ready=0, pending=8'h30, assert rst_n=0 for one edge → all outputs reach reset values on that edge.
  - No stale index appears after release.
